// File: rtl/la_capture_ctrl_if.sv
// Divider control and sample-RAM write bus between the capture sequencer
// (master) and the divider/RAM datapath (slave).
interface la_capture_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              div_start;
   logic [3:0]        div_cfg;
   logic              sample_tick;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output div_start, div_cfg, wr_en, wr_addr, wr_data,
      input  sample_tick
   );

   modport slave (
      input  div_start, div_cfg, wr_en, wr_addr, wr_data,
      output sample_tick
   );
endinterface

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: gates the sample divider, writes probe
// samples into a circular RAM, and tracks pre-trigger, trigger and post window.
module la_capture_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [3:0]        cfg_rate_i,
   input  logic [ADDR_W-1:0] cfg_pre_i,
   input  logic [ADDR_W-1:0] cfg_post_i,
   input  logic [DATA_W-1:0] trig_mask_i,
   input  logic [DATA_W-1:0] trig_value_i,
   input  logic              trig_force_i,
   input  logic [DATA_W-1:0] probe_i,
   output logic              busy_o,
   output logic              triggered_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] trig_addr_o,
   la_capture_ctrl_if.master bus
);
   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_TRIG, S_POST, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0]  pre_q, post_q, room, post_eff_d;
   logic [DATA_W-1:0] mask_q, value_q, wr_data_q;
   logic [ADDR_W-1:0] ptr_q, wr_addr_q, trig_addr_q;
   logic [3:0]        div_cfg_q;
   logic              div_start_q, busy_q, triggered_q, done_q, wr_en_q;
   logic              accept, active, busy_d, take_tick, match, trig_hit;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      trig_hit  = 1'b0;
      active    = (state_q == S_ARM) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
      take_tick = active && bus.sample_tick;
      match     = ((probe_i & mask_q) == (value_q & mask_q)) || trig_force_i;
      cnt_inc   = cnt_q + CNT_W'(1);
      // Post window is clipped so it can never wrap onto its own pre-trigger samples.
      room       = {1'b0, {ADDR_W{1'b1}}} - {1'b0, cfg_pre_i};
      post_eff_d = ({1'b0, cfg_post_i} < room) ? {1'b0, cfg_post_i} : room;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i && !abort_i) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = (cfg_pre_i == '0) ? S_WAIT_TRIG : S_ARM;
            end
         end
         S_ARM: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (take_tick) begin
               if (cnt_inc == pre_q) begin
                  state_d = S_WAIT_TRIG;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_WAIT_TRIG: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (take_tick && match) begin
               trig_hit = 1'b1;
               cnt_d    = '0;
               state_d  = (post_q == '0) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (take_tick) begin
               if (cnt_inc == post_q) state_d = S_DONE;
               else                   cnt_d   = cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_ARM) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pre_q       <= '0;
         post_q      <= '0;
         mask_q      <= '0;
         value_q     <= '0;
         ptr_q       <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
         trig_addr_q <= '0;
         div_cfg_q   <= 4'h0;
         div_start_q <= 1'b0;
         busy_q      <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         div_start_q <= busy_d;
         done_q      <= (state_d == S_DONE);
         wr_en_q     <= take_tick;
         if (take_tick) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= probe_i;
            ptr_q     <= ptr_q + ADDR_W'(1);
         end
         if (accept) begin
            pre_q       <= {1'b0, cfg_pre_i};
            post_q      <= post_eff_d;
            mask_q      <= trig_mask_i;
            value_q     <= trig_value_i;
            div_cfg_q   <= cfg_rate_i;
            ptr_q       <= '0;
            wr_addr_q   <= '0;
            triggered_q <= 1'b0;
         end
         if (trig_hit) begin
            trig_addr_q <= ptr_q;
            triggered_q <= 1'b1;
         end
      end
   end

   assign bus.div_start = div_start_q;
   assign bus.div_cfg   = div_cfg_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign busy_o        = busy_q;
   assign triggered_o   = triggered_q;
   assign done_o        = done_q;
   assign trig_addr_o   = trig_addr_q;
endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with a 16-entry sample RAM (ADDR_W=4).
module tb_la_capture_ctrl;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst;
   logic              start, abort, trig_force;
   logic [3:0]        cfg_rate;
   logic [ADDR_W-1:0] cfg_pre, cfg_post, trig_addr;
   logic [DATA_W-1:0] trig_mask, trig_value, probe;
   logic              busy, triggered, done;

   int errors = 0;
   int checks = 0;

   la_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   la_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .abort_i      (abort),
      .cfg_rate_i   (cfg_rate),
      .cfg_pre_i    (cfg_pre),
      .cfg_post_i   (cfg_post),
      .trig_mask_i  (trig_mask),
      .trig_value_i (trig_value),
      .trig_force_i (trig_force),
      .probe_i      (probe),
      .busy_o       (busy),
      .triggered_o  (triggered),
      .done_o       (done),
      .trig_addr_o  (trig_addr),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample-RAM model fed from the write strobe, sampled on the falling edge.
   logic [DATA_W-1:0] mem [16];
   int                wr_total  = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         mem[bus.wr_addr] = bus.wr_data;
         last_addr        = bus.wr_addr;
         wr_total++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string p);
      check({p, "_div_start"}, 32'(bus.div_start), 0);
      check({p, "_div_cfg"},   32'(bus.div_cfg),   0);
      check({p, "_wr_en"},     32'(bus.wr_en),     0);
      check({p, "_wr_addr"},   32'(bus.wr_addr),   0);
      check({p, "_wr_data"},   32'(bus.wr_data),   0);
      check({p, "_busy"},      32'(busy),          0);
      check({p, "_triggered"}, 32'(triggered),     0);
      check({p, "_done"},      32'(done),          0);
      check({p, "_trig_addr"}, 32'(trig_addr),     0);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Runs n cycles with one tick per cycle; records the first cycle at which
   // triggered/done are seen, plus the write strobe at the done cycle.
   task automatic run(input int n, input int hit_k, input int arm_hits, input bit ramp,
                      output int trig_k, output int done_k,
                      output logic done_wen, output logic [ADDR_W-1:0] done_waddr);
      trig_k = -1;
      done_k = -1;
      done_wen = 1'b0;
      done_waddr = '0;
      for (int k = 0; k < n; k++) begin
         if (ramp) probe = 8'h30 + 8'(k);
         else      probe = (k == hit_k || k < arm_hits) ? 8'hA5 : 8'h00;
         step();
         if (trig_k < 0 && triggered === 1'b1) trig_k = k;
         if (done_k < 0 && done === 1'b1) begin
            done_k     = k;
            done_wen   = bus.wr_en;
            done_waddr = bus.wr_addr;
         end
      end
      probe = 8'h00;
   endtask

   int                tk, dk, base, cfg_bad;
   logic              dwen;
   logic [ADDR_W-1:0] dwa;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; trig_force = 1'b0;
      cfg_rate = 4'hd; cfg_pre = 4'd3; cfg_post = 4'd4;
      trig_mask = 8'hFF; trig_value = 8'hA5; probe = 8'h00;
      bus.sample_tick = 1'b1;
      step();
      step();
      check_reset("rst0");
      rst = 1'b0;

      // Basic capture: pre=3, post=4, trigger on sample 5.
      base = wr_total;
      do_start();
      check("t1_div_start_rise", 32'(bus.div_start), 1);
      check("t1_div_cfg",        32'(bus.div_cfg),   32'hd);
      check("t1_busy",           32'(busy),          1);
      run(15, 5, 0, 1'b0, tk, dk, dwen, dwa);
      check("t1_trig_cycle",     32'(tk), 5);
      check("t1_trig_addr",      32'(trig_addr), 5);
      check("t1_done_cycle",     32'(dk), 9);
      check("t1_done_with_wr",   32'(dwen), 1);
      check("t1_done_wr_addr",   32'(dwa), 9);
      check("t1_writes",         32'(wr_total - base), 10);
      check("t1_last_addr",      32'(last_addr), 9);
      check("t1_mem5",           32'(mem[5]), 32'hA5);
      check("t1_mem4",           32'(mem[4]), 0);
      check("t1_done",           32'(done), 1);
      check("t1_div_start_low",  32'(bus.div_start), 0);
      check("t1_busy_low",       32'(busy), 0);

      // Matches in ARM ignored; trigger on the first later match (sample 6).
      cfg_post = 4'd2;
      base = wr_total;
      do_start();
      check("t2_done_cleared",   32'(done), 0);
      check("t2_trig_cleared",   32'(triggered), 0);
      run(12, 6, 3, 1'b0, tk, dk, dwen, dwa);
      check("t2_trig_cycle",     32'(tk), 6);
      check("t2_trig_addr",      32'(trig_addr), 6);
      check("t2_done_cycle",     32'(dk), 8);
      check("t2_writes",         32'(wr_total - base), 9);

      // Clipped post window: pre=10, post=15 -> 5 post samples, 16 writes.
      cfg_pre = 4'd10; cfg_post = 4'd15; trig_value = 8'h3A;
      base = wr_total;
      do_start();
      run(20, 0, 0, 1'b1, tk, dk, dwen, dwa);
      check("t3_trig_addr",      32'(trig_addr), 10);
      check("t3_done_cycle",     32'(dk), 15);
      check("t3_writes",         32'(wr_total - base), 16);
      check("t3_last_addr",      32'(last_addr), 15);
      check("t3_mem0",           32'(mem[0]), 32'h30);
      check("t3_mem15",          32'(mem[15]), 32'h3F);

      // Address wrap: pre=14, post=9 -> 1 post sample; trigger on sample 18 at addr 2.
      cfg_pre = 4'd14; cfg_post = 4'd9; trig_value = 8'h42;
      base = wr_total;
      do_start();
      run(24, 0, 0, 1'b1, tk, dk, dwen, dwa);
      check("t3b_trig_addr",     32'(trig_addr), 2);
      check("t3b_done_cycle",    32'(dk), 19);
      check("t3b_writes",        32'(wr_total - base), 20);
      check("t3b_last_addr",     32'(last_addr), 3);
      check("t3b_mem0_wrapped",  32'(mem[0]), 32'h40);
      check("t3b_mem3",          32'(mem[3]), 32'h43);
      check("t3b_mem4",          32'(mem[4]), 32'h34);

      // Abort in POST, then simultaneous start+abort from IDLE.
      cfg_pre = 4'd2; cfg_post = 4'd8; trig_value = 8'hA5;
      do_start();
      run(5, 3, 0, 1'b0, tk, dk, dwen, dwa);
      check("t4_in_post_busy",   32'(busy), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t4_abort_busy",     32'(busy), 0);
      check("t4_abort_div",      32'(bus.div_start), 0);
      check("t4_abort_done",     32'(done), 0);
      check("t4_abort_trig",     32'(triggered), 1);
      step();
      check("t4_idle_no_wr",     32'(bus.wr_en), 0);
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("t4_sa_busy",        32'(busy), 0);
      check("t4_sa_div",         32'(bus.div_start), 0);
      check("t4_sa_trig_kept",   32'(triggered), 1);

      // Rate 3, forced trigger, ticks every other cycle.
      cfg_rate = 4'h3; cfg_pre = 4'd2; cfg_post = 4'd1; trig_force = 1'b1;
      bus.sample_tick = 1'b0;
      base = wr_total;
      cfg_bad = 0;
      tk = -1;
      do_start();
      check("t5_div_start",      32'(bus.div_start), 1);
      check("t5_div_cfg",        32'(bus.div_cfg), 32'h3);
      for (int c = 0; c < 12; c++) begin
         bus.sample_tick = (c % 2 == 0);
         step();
         if (bus.div_start === 1'b1 && bus.div_cfg !== 4'h3) cfg_bad++;
         if (tk < 0 && triggered === 1'b1) tk = c;
      end
      trig_force = 1'b0;
      bus.sample_tick = 1'b1;
      check("t5_cfg_stable",     32'(cfg_bad), 0);
      check("t5_trig_cycle",     32'(tk), 4);
      check("t5_trig_addr",      32'(trig_addr), 2);
      check("t5_done",           32'(done), 1);
      check("t5_writes",         32'(wr_total - base), 4);

      // Synchronous reset while waiting for the trigger.
      cfg_rate = 4'hd; cfg_pre = 4'd1; cfg_post = 4'd3; probe = 8'h00;
      do_start();
      step();
      step();
      check("t6_wait_busy",      32'(busy), 1);
      check("t6_wait_untrig",    32'(triggered), 0);
      rst = 1'b1;
      step();
      check_reset("t6");
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
